// File: rtl/p09_debouncer.sv
// Multi-channel button debouncer with per-channel counters and registered edge pulses.
// Optional auto-repeat on the act output is enabled by defining P09_DEBOUNCE_AUTOREPEAT_EN.
module p09_debouncer #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE   = {WIDTH{1'b0}},
    parameter int               REPEAT_DELAY    = 1000,
    parameter int               REPEAT_PERIOD   = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] act
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("p09_debouncer: DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("p09_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

`ifdef P09_DEBOUNCE_AUTOREPEAT_EN
    localparam int            RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW          = $clog2(RMAX);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d;
        logic          st_q, st_d;
        logic          rise_q, fall_q;
        logic          differ, accept;

        // The counter holds how many differing samples have been seen so far;
        // the sample that would make it DEBOUNCE_CYCLES flips the state instead.
        assign differ = in[g] ^ st_q;
        assign accept = differ && (cnt_q == CNT_LAST);
        assign cnt_d  = (!differ || accept) ? '0 : cnt_q + 1'b1;
        assign st_d   = st_q ^ accept;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                st_q   <= DEFAULT_VALUE[g];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                st_q   <= st_d;
                rise_q <= accept && !st_q;
                fall_q <= accept && st_q;
            end
        end

        assign state[g] = st_q;
        assign rise[g]  = rise_q;
        assign fall[g]  = fall_q;

`ifdef P09_DEBOUNCE_AUTOREPEAT_EN
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          first_q, first_d;
        logic          act_q;
        logic          rep_hit;

        // Repeat timer runs only while the debounced level is high and not falling;
        // first_q selects the initial delay before switching to the steady period.
        assign rep_hit = st_q && !accept && (rcnt_q == (first_q ? DELAY_LAST : PERIOD_LAST));

        always_comb begin
            rcnt_d  = rcnt_q + 1'b1;
            first_d = first_q;
            if (!st_q || accept) begin
                rcnt_d  = '0;
                first_d = 1'b1;
            end else if (rep_hit) begin
                rcnt_d  = '0;
                first_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rcnt_q  <= '0;
                first_q <= 1'b1;
                act_q   <= 1'b0;
            end else begin
                rcnt_q  <= rcnt_d;
                first_q <= first_d;
                act_q   <= (accept && !st_q) || rep_hit;
            end
        end

        assign act[g] = act_q;
`else
        assign act[g] = rise_q;
`endif
    end

endmodule

// File: tb/tb_p09_debouncer.sv
// Bench for p09_debouncer: directed scenarios plus randomized levels against a cycle-count model.
module tb_p09_debouncer;

    localparam int W   = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_v = '0;
    logic [W-1:0] state, rise, fall, act;

    int checks = 0;
    int errors = 0;

    // Reference model: run length of differing samples and cycles since the accepted press.
    int           run   [W];
    int           since [W];
    logic [W-1:0] m_state, m_rise, m_fall, m_act;

    p09_debouncer #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .DEFAULT_VALUE(4'b0000),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .in(in_v),
        .state(state), .rise(rise), .fall(fall), .act(act)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic [W-1:0] x, input logic r);
        for (int i = 0; i < W; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_act[i]  = 1'b0;
            if (r) begin
                m_state[i] = 1'b0;
                run[i]     = 0;
                since[i]   = -1;
            end else begin
                run[i] = (x[i] == m_state[i]) ? 0 : run[i] + 1;
                if (run[i] == DEB) begin
                    run[i]     = 0;
                    m_state[i] = ~m_state[i];
                    m_rise[i]  = m_state[i];
                    m_fall[i]  = ~m_state[i];
                end
                if (m_rise[i]) since[i] = 0;
                else if (m_fall[i] || !m_state[i]) since[i] = -1;
                else since[i] = since[i] + 1;
`ifdef P09_DEBOUNCE_AUTOREPEAT_EN
                m_act[i] = (since[i] == 0) || (since[i] == RD) ||
                           (since[i] > RD && ((since[i] - RD) % RP) == 0);
`else
                m_act[i] = m_rise[i];
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock: model sees the same sampled inputs, outputs compared 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge(in_v, rst);
        #1;
        chk("state", state, m_state);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("act", act, m_act);
    endtask

    int rise_at;
    int both_seen;
    int hold_left [W];

    initial begin
        for (int i = 0; i < W; i++) begin
            run[i] = 0; since[i] = -1; hold_left[i] = 0;
        end
        m_state = '0; m_rise = '0; m_fall = '0; m_act = '0;

        // Reset held two cycles with inputs low.
        rst = 1'b1; in_v = '0;
        tick(); tick();
        chk("reset_state", state, 4'b0000);
        rst = 1'b0;

        // Press on channel 0: rise on the 4th sampling edge only.
        in_v[0] = 1'b1;
        rise_at = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (rise[0]) rise_at = k;
        end
        chk_int("press_latency", rise_at, DEB);

        // Glitch of 3 cycles on channel 1 must be ignored.
        in_v[1] = 1'b1;
        repeat (3) tick();
        in_v[1] = 1'b0;
        repeat (5) tick();
        chk("glitch_state", state, 4'b0001);

        // Bring channel 3 high, then swap channels 2 and 3 together.
        in_v[3] = 1'b1;
        repeat (6) tick();
        in_v[2] = 1'b1; in_v[3] = 1'b0;
        both_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rise[2] && fall[3]) both_seen++;
        end
        chk_int("simultaneous_edges", both_seen, 1);

        // Reset aborts a partial count on channel 0.
        in_v = '0;
        repeat (6) tick();
        in_v[0] = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rise_at = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (rise[0]) rise_at = k;
        end
        chk_int("reset_abort_latency", rise_at, DEB);

        // Long hold exercises auto-repeat when enabled, then release.
        in_v = '0;
        repeat (6) tick();
        in_v[0] = 1'b1;
        repeat (40) tick();
        in_v[0] = 1'b0;
        repeat (12) tick();

        // Randomized per-channel levels with random hold lengths and rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                if (hold_left[i] == 0) begin
                    in_v[i]      = 1'($urandom_range(0, 1));
                    hold_left[i] = $urandom_range(1, 24);
                end else begin
                    hold_left[i]--;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/p09_debouncer.md
P09_DEBOUNCER -- requirements
Module: p09_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive differing samples required to accept a change (legal 2..65535).
REQ-003 SHALL have parameter DEFAULT_VALUE, default {WIDTH{1'b0}}, reset value of debounced state.
REQ-004 SHALL have parameter REPEAT_DELAY, default 1000, cycles from accepted press to first repeat (used only with the macro in REQ-020; legal >=2).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 250, cycles between subsequent repeats (used only with the macro in REQ-020; legal >=2).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 in  input  WIDTH  button levels, already two-flop synchronized to clk upstream.
REQ-009 state  output  WIDTH  registered debounced level per channel.
REQ-010 rise  output  WIDTH  one-cycle pulse per channel on accepted 0->1.
REQ-011 fall  output  WIDTH  one-cycle pulse per channel on accepted 1->0.
REQ-012 act  output  WIDTH  one-cycle "action" pulse per channel (press plus optional repeats).

Function
REQ-013 SHALL give each channel a private counter, sized from DEBOUNCE_CYCLES by clog2; channels SHALL NOT interact.
REQ-014 SHALL clear a channel's counter on any edge where in[i]==state[i]; otherwise SHALL increment it.
REQ-015 SHALL toggle state[i] and clear the counter on the edge that samples the DEBOUNCE_CYCLES-th consecutive differing value of in[i].
REQ-016 SHALL assert rise[i] or fall[i] for exactly the cycle in which the new state[i] is first visible; all outputs registered, no combinational path from in.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no state change and no pulse.
REQ-018 SHALL update multiple channels in the same cycle independently, with simultaneous rise on one channel and fall on another permitted.
REQ-019 Without the macro in REQ-020, act SHALL equal rise.

Configuration
REQ-020 With P09_DEBOUNCE_AUTOREPEAT_EN defined, each channel SHALL add a repeat counter: act[i] pulses with rise[i], then again REPEAT_DELAY cycles after that pulse, then every REPEAT_PERIOD cycles while state[i]==1.
REQ-021 With P09_DEBOUNCE_AUTOREPEAT_EN defined, an accepted fall SHALL clear the repeat counter, and no act pulse SHALL occur in or after the fall cycle.
REQ-022 Without P09_DEBOUNCE_AUTOREPEAT_EN, repeat logic and the REPEAT_* parameters SHALL have no effect and generate no hardware.

Reset
REQ-023 While rst is high at an edge: state=DEFAULT_VALUE; rise, fall and act = 0; all counters = 0.
REQ-024 Reset SHALL abort any in-progress debounce or repeat count; after release a full DEBOUNCE_CYCLES count is required.
REQ-025 If in differs from DEFAULT_VALUE after reset, the block SHALL debounce normally and emit rise or fall on acceptance.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-026 rst=1 two cycles with in=0 -> state=0, rise=fall=act=0 throughout.
REQ-027 in[0] 0->1 held -> state[0]=1 and rise[0]=1 in the cycle after the 4th sampling edge; rise[0] low the next cycle.
REQ-028 in[1] high 3 cycles then low -> state[1] stays 0; no rise, fall or act on any channel.
REQ-029 state[2]=0 and state[3]=1; in[2]=1 and in[3]=0 on the same edge, both held -> rise[2] and fall[3] pulse in the same cycle.
REQ-030 in[0] high, rst pulsed after 2 counted cycles, in[0] still high -> rise[0] only after 4 further edges following rst release.
REQ-031 With the macro defined, in[0] held high 40 cycles -> act[0] pulses at rise, then at +10 and +15 cycles; release yields fall[0] and no further act.
